clock_divider: RTL and testbench

- Divides the fast board clock by 2^BITS to produce a slow, 50%-duty system clock (div_clk) for the SoC core, so instruction-fetch and state changes are visible on LEDs.
- Also produces a companion reset (div_reset) that is aligned to the divided-clock domain.
- Sits at the top level between the board clock/reset pins and the rest of the design.
- div_reset changes only on div_clk falling edges, so it is always stable at div_clk rising edges.

---
 rtl/clock_divider.sv | 90 +++++++++
 tb/tb_clock_divider.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// clock_divider
//   Divides the fast board clock by 2^BITS into a 50%-duty divided clock and
//   generates a reset aligned to that divided-clock domain.
//
//   Ports:
//     clk        in   fast board clock, all flops on its rising edge
//     reset      in   synchronous active-high reset
//     div_clk    out  divided clock, counter MSB, registered
//     div_reset  out  active-high reset for the div_clk domain; changes only
//                     on div_clk falling edges
//     rise_tick  out  one-clk pulse in the first clk cycle with div_clk high
//
//   Parameters:
//     BITS        divider width, div_clk period = 2^BITS clk cycles (2..32)
//     RESET_HOLD  div_clk rising edges seen with div_reset high (1..255)
module clock_divider #(
  parameter int unsigned BITS       = 24,
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic clk,
  input  logic reset,
  output logic div_clk,
  output logic div_reset,
  output logic rise_tick
);

  localparam logic [BITS-1:0] CNT_ONE  = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] CNT_HALF = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] CNT_ZERO = {BITS{1'b0}};
  localparam logic [7:0]      HOLD_C   = 8'(RESET_HOLD);

  logic [BITS-1:0] cnt_q, cnt_d;
  logic [7:0]      hc_q, hc_d;
  logic            div_clk_q, div_clk_d;
  logic            div_reset_q, div_reset_d;
  logic            rise_tick_q, rise_tick_d;

  // Next-state logic for the divider counter, hold counter and outputs.
  always_comb begin
    cnt_d       = cnt_q;
    hc_d        = hc_q;
    div_reset_d = div_reset_q;

    if (reset) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (reset) begin
      div_reset_d = 1'b1;
      hc_d        = 8'd0;
    end else if (div_reset_q) begin
      // cnt_d == HALF marks a div_clk rising edge; count it up to the hold.
      if ((cnt_d == CNT_HALF) && (hc_q != HOLD_C)) begin
        hc_d = hc_q + 8'd1;
      end else begin
        hc_d = hc_q;
      end
      // Release only on a div_clk falling edge so the downstream domain
      // never sees div_reset change near its active edge.
      if ((cnt_d == CNT_ZERO) && (hc_q == HOLD_C)) begin
        div_reset_d = 1'b0;
      end else begin
        div_reset_d = 1'b1;
      end
    end else begin
      hc_d        = hc_q;
      div_reset_d = 1'b0;
    end

    // Registered copy of the counter MSB keeps div_clk glitch-free.
    div_clk_d   = cnt_d[BITS-1];
    rise_tick_d = (!reset) && (cnt_d == CNT_HALF);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    cnt_q       <= cnt_d;
    hc_q        <= hc_d;
    div_clk_q   <= div_clk_d;
    div_reset_q <= div_reset_d;
    rise_tick_q <= rise_tick_d;
  end

  assign div_clk   = div_clk_q;
  assign div_reset = div_reset_q;
  assign rise_tick = rise_tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider
//   Directed bench for clock_divider. Three instances share one clock:
//     A: BITS=4 RESET_HOLD=2   B: BITS=4 RESET_HOLD=1   C: BITS=2 RESET_HOLD=3
//   Edge count k is the number of clk edges since the last reset edge.
module tb_clock_divider;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic dclk_a, drst_a, tick_a;
  logic dclk_b, drst_b, tick_b;
  logic dclk_c, drst_c, tick_c;

  int total;
  int bad;

  clock_divider #(.BITS(4), .RESET_HOLD(2)) u_a (
    .clk(clk), .reset(rst_a), .div_clk(dclk_a), .div_reset(drst_a), .rise_tick(tick_a)
  );
  clock_divider #(.BITS(4), .RESET_HOLD(1)) u_b (
    .clk(clk), .reset(rst_b), .div_clk(dclk_b), .div_reset(drst_b), .rise_tick(tick_b)
  );
  clock_divider #(.BITS(2), .RESET_HOLD(3)) u_c (
    .clk(clk), .reset(rst_c), .div_clk(dclk_c), .div_reset(drst_c), .rise_tick(tick_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0b expected=%0b", tag, k, obs, exp);
    end
  endtask

  // One clk edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected values for a 16-cycle divider: rises at k%16==8, falls at wrap.
  function automatic logic exp_clk16(input int k);
    return ((k % 16) >= 8) ? 1'b1 : 1'b0;
  endfunction
  function automatic logic exp_tick16(input int k);
    return ((k % 16) == 8) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    int k;
    int j;
    total = 0;
    bad   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;

    // Reset values held over several edges.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_clk",  i, dclk_a, 1'b0);
      chk("rst_a_drst", i, drst_a, 1'b1);
      chk("rst_a_tick", i, tick_a, 1'b0);
      chk("rst_b_drst", i, drst_b, 1'b1);
      chk("rst_c_clk",  i, dclk_c, 1'b0);
      chk("rst_c_drst", i, drst_c, 1'b1);
      chk("rst_c_tick", i, tick_c, 1'b0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    // Release: A releases at k=32, B at k=16, C (period 4) at k=12.
    k = 0;
    for (int i = 1; i <= 44; i++) begin
      step();
      k = i;
      chk("a_clk",  k, dclk_a, exp_clk16(k));
      chk("a_tick", k, tick_a, exp_tick16(k));
      chk("a_drst", k, drst_a, (k < 32) ? 1'b1 : 1'b0);
      chk("b_clk",  k, dclk_b, exp_clk16(k));
      chk("b_drst", k, drst_b, (k < 16) ? 1'b1 : 1'b0);
      chk("c_clk",  k, dclk_c, ((k % 4) >= 2) ? 1'b1 : 1'b0);
      chk("c_tick", k, tick_c, ((k % 4) == 2) ? 1'b1 : 1'b0);
      chk("c_drst", k, drst_c, (k < 12) ? 1'b1 : 1'b0);
    end

    // Hand-picked edges: div_reset as seen by the div_clk rising edges.
    // At k=44 A is high (cnt=12); the single-cycle reset lands on edge 45.
    rst_a = 1'b1;
    step();
    k = 45;
    chk("a_mid_clk",  k, dclk_a, 1'b0);
    chk("a_mid_drst", k, drst_a, 1'b1);
    chk("a_mid_tick", k, tick_a, 1'b0);
    rst_a = 1'b0;

    // A restarts relative to edge 45; B and C keep free running.
    for (int i = 1; i <= 240; i++) begin
      step();
      j = i;
      k = 45 + i;
      chk("a2_clk",  j, dclk_a, exp_clk16(j));
      chk("a2_tick", j, tick_a, exp_tick16(j));
      chk("a2_drst", j, drst_a, (j < 32) ? 1'b1 : 1'b0);
      chk("b_run_clk",  k, dclk_b, exp_clk16(k));
      chk("b_run_tick", k, tick_b, exp_tick16(k));
      chk("b_run_drst", k, drst_b, 1'b0);
      chk("c_run_clk",  k, dclk_c, ((k % 4) >= 2) ? 1'b1 : 1'b0);
      chk("c_run_drst", k, drst_c, 1'b0);
    end

    // Long reset on C: outputs pinned, no div_clk edges.
    rst_c = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("c_hold_clk",  i, dclk_c, 1'b0);
      chk("c_hold_drst", i, drst_c, 1'b1);
      chk("c_hold_tick", i, tick_c, 1'b0);
    end
    rst_c = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("c2_clk",  i, dclk_c, ((i % 4) >= 2) ? 1'b1 : 1'b0);
      chk("c2_drst", i, drst_c, (i < 12) ? 1'b1 : 1'b0);
    end

    // Reset on B coinciding with its hc increment edge (cnt becoming 8).
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    rst_b = 1'b1;
    step();
    chk("b_win_clk",  0, dclk_b, 1'b0);
    chk("b_win_tick", 0, tick_b, 1'b0);
    chk("b_win_drst", 0, drst_b, 1'b1);
    rst_b = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      chk("b2_clk",  i, dclk_b, exp_clk16(i));
      chk("b2_drst", i, drst_b, (i < 16) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
